mine_map_gen: RTL and testbench

Generates the 64-cell mine map for a new game: places exactly `NUM_MINES` mines at pseudo-random cells, never on cells flagged in `exclude`. It then presents the finished map on `mm_out` with a one-cycle `ld_mm` strobe. It sits directly upstream of the game datapath: `mm_out` drives `MMin` and `ld_mm` drives `ldMM` of the mine-map register.

---
 rtl/mine_map_gen.sv | 153 +++++++++++++++
 tb/tb_mine_map_gen.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mine_map_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mine_map_gen
//
// Builds the 64-cell mine map for a new game. Exactly NUM_MINES mines are put
// at pseudo-random cells, and no mine goes on a cell flagged in `exclude`. The
// finished map is shown on mm_out together with a one-cycle ld_mm strobe, which
// loads the downstream mine-map register.
//
// Parameters
//   NUM_MINES  mines per map (1..63)
//   SEED       LFSR reset value (nonzero)
//   MAX_TRIES  placement attempts allowed before the run aborts (64..65535)
//
// Ports
//   clk      in   system clock, rising edge
//   resetn   in   asynchronous active-low reset
//   start    in   request a new map; only looked at in IDLE
//   exclude  in   [63:0] cells that must stay mine-free; hold stable while busy
//   mm_out   out  [63:0] mine map, bit i = cell i
//   ld_mm    out  one-cycle strobe; mm_out is final in this cycle
//   busy     out  high while clearing, placing or loading
//   done     out  high after a successful load until the next accepted start
//   err      out  high after an abort until the next accepted start
// -----------------------------------------------------------------------------
module mine_map_gen #(
  parameter int unsigned NUM_MINES = 10,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned MAX_TRIES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [63:0] exclude,
  output logic [63:0] mm_out,
  output logic        ld_mm,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_PLACE,
    S_LOAD
  } state_e;

  localparam logic [6:0]  NUM_MINES_C = 7'(NUM_MINES);
  localparam logic [15:0] MAX_TRIES_C = 16'(MAX_TRIES);

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [63:0] map_q, map_d;
  logic [6:0]  count_q, count_d;
  logic [15:0] tries_q, tries_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [5:0]  idx;
  logic        hit;
  logic [6:0]  count_inc;
  logic [15:0] tries_inc;

  // NOTE: every signal written in this block gets a value at the top. That way
  // no path leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    map_d   = map_q;
    count_d = count_q;
    tries_d = tries_q;
    done_d  = done_q;
    err_d   = err_q;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1. It runs freely in every state, so
    // the cycle on which start arrives changes the map.
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    idx       = lfsr_q[5:0];
    hit       = ~map_q[idx] & ~exclude[idx];
    count_inc = count_q + 7'd1;
    tries_inc = tries_q + 16'd1;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end

      S_CLEAR: begin
        map_d   = '0;
        count_d = '0;
        tries_d = '0;
        state_d = S_PLACE;
      end

      S_PLACE: begin
        tries_d = tries_inc;
        if (hit) begin
          map_d[idx] = 1'b1;
          count_d    = count_inc;
        end
        // A success that completes the map takes priority over the try limit
        // being reached on the same attempt.
        if (hit && (count_inc == NUM_MINES_C)) begin
          state_d = S_LOAD;
        end else if (tries_inc == MAX_TRIES_C) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_LOAD: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments. All flops then sample
  // their pre-edge _d values together, whatever order the simulator runs them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      map_q   <= '0;
      count_q <= '0;
      tries_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      map_q   <= map_d;
      count_q <= count_d;
      tries_q <= tries_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mm_out = map_q;
  assign ld_mm  = (state_q == S_LOAD);
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mine_map_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mine_map_gen
//
// Self-checking bench for mine_map_gen. A reference model works out the whole
// generation run when a start is accepted. From the LFSR value at that moment
// it finds the final map, the number of attempts and whether the run aborts.
// The model then shows the expected output timeline cycle by cycle. One compare
// process checks the DUT outputs against that timeline on every falling edge.
// Directed scenarios add property checks and a few literal expectations.
// -----------------------------------------------------------------------------
module tb_mine_map_gen;

  localparam int unsigned N     = 10;
  localparam int unsigned MAXT  = 1024;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [63:0] exclude;
  logic [63:0] mm_out;
  logic        ld_mm;
  logic        busy;
  logic        done;
  logic        err;

  mine_map_gen #(
    .NUM_MINES (N),
    .SEED      (SEED),
    .MAX_TRIES (MAXT)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .exclude (exclude),
    .mm_out  (mm_out),
    .ld_mm   (ld_mm),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Whole run from the LFSR value seen in the cycle where start is sampled.
  // CLEAR uses one step, so the first attempt sees the value two steps later.
  task automatic predict(input logic [15:0] l0, input logic [63:0] ex,
                         output logic [63:0] map, output int n, output bit e);
    logic [15:0] l;
    int          cnt;
    int          idx;
    l   = lfsr_step(lfsr_step(l0));
    map = '0;
    cnt = 0;
    n   = 0;
    e   = 1'b0;
    for (int t = 1; t <= int'(MAXT); t++) begin
      idx = int'(l[5:0]);
      if (!map[idx] && !ex[idx]) begin
        map[idx] = 1'b1;
        cnt++;
      end
      if (cnt == int'(N)) begin
        n = t;
        return;
      end
      if (t == int'(MAXT)) begin
        n = t;
        e = 1'b1;
        return;
      end
      l = lfsr_step(l);
    end
  endtask

  logic [15:0] m_lfsr;
  bit          m_active;
  int          m_k;
  logic [63:0] p_map;
  int          p_n;
  bit          p_err;
  logic        exp_busy, exp_ld, exp_done, exp_err;
  logic [63:0] exp_map;
  bit          exp_map_valid;

  // Expected outputs after each rising edge; k counts edges since the start edge.
  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      m_lfsr        = SEED;
      m_active      = 1'b0;
      m_k           = 0;
      exp_busy      = 1'b0;
      exp_ld        = 1'b0;
      exp_done      = 1'b0;
      exp_err       = 1'b0;
      exp_map       = '0;
      exp_map_valid = 1'b1;
    end else begin
      if (m_active) begin
        m_k++;
        if (m_k == 1) exp_map_valid = 1'b0;
        if (!p_err && m_k == p_n + 1) begin
          exp_ld        = 1'b1;
          exp_map       = p_map;
          exp_map_valid = 1'b1;
        end else if (!p_err && m_k == p_n + 2) begin
          exp_ld   = 1'b0;
          exp_busy = 1'b0;
          exp_done = 1'b1;
          m_active = 1'b0;
        end else if (p_err && m_k == p_n + 1) begin
          exp_busy      = 1'b0;
          exp_err       = 1'b1;
          exp_map       = p_map;
          exp_map_valid = 1'b1;
          m_active      = 1'b0;
        end
      end else if (start) begin
        predict(m_lfsr, exclude, p_map, p_n, p_err);
        m_active = 1'b1;
        m_k      = 0;
        exp_busy = 1'b1;
        exp_done = 1'b0;
        exp_err  = 1'b0;
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  // ---------------------------------------------------------------------------
  // Cycle counter, compare process and event monitor
  // ---------------------------------------------------------------------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ld_count    = 0;
  int ld_cyc      = 0;
  int done_rises  = 0;
  int err_cyc     = 0;
  bit done_prev   = 1'b0;
  bit err_prev    = 1'b0;
  int start_cyc   = 0;

  initial forever begin
    @(negedge clk);
    if (resetn) begin
      check("cmp_busy",  64'(busy),  64'(exp_busy));
      check("cmp_ld_mm", 64'(ld_mm), 64'(exp_ld));
      check("cmp_done",  64'(done),  64'(exp_done));
      check("cmp_err",   64'(err),   64'(exp_err));
      if (exp_map_valid) check("cmp_mm_out", mm_out, exp_map);
      if (ld_mm) begin
        ld_count++;
        ld_cyc = cyc;
      end
      if (done && !done_prev) done_rises++;
      if (err && !err_prev) err_cyc = cyc;
      done_prev = done;
      err_prev  = err;
    end else begin
      done_prev = 1'b0;
      err_prev  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic apply_reset();
    resetn = 1'b0;
    start  = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic do_start();
    @(negedge clk);
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Raise start once n rising edges have passed since the reset release.
  task automatic start_at(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_timeout"}, 64'(ok), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  logic [63:0] map_a;
  logic [63:0] pm;
  int          pn;
  bit          pe;
  int          ld0;
  int          dr0;

  initial begin
    resetn  = 1'b0;
    start   = 1'b0;
    exclude = 64'h1;

    // Pin the model itself with hand-worked values.
    check("pin_lfsr_step1", 64'(lfsr_step(SEED)), 64'h59C3);
    check("pin_lfsr_step2", 64'(lfsr_step(lfsr_step(SEED))), 64'hB387);
    predict(SEED, 64'hFFFF_FFFF_FFFF_FFF8, pm, pn, pe);
    check("pin_model_abort_err",  64'(pe), 64'd1);
    check("pin_model_abort_n",    64'(pn), 64'(MAXT));
    check("pin_model_abort_mask", pm & ~64'h7, 64'h0);

    apply_reset();
    #1;
    check("reset_mm_out", mm_out, 64'h0);
    check("reset_flags", {60'h0, ld_mm, busy, done, err}, 64'h0);

    // Determinism: a start 5 cycles after reset gives a known map in 11 attempts.
    exclude = 64'h1;
    start_at(5);
    wait_idle(1100, "det_a");
    map_a = mm_out;
    check("det_a_literal_map", mm_out, 64'h0004_0C14_0022_0520);
    check("det_a_latency", 64'(ld_cyc - start_cyc), 64'd13);

    apply_reset();
    start_at(5);
    wait_idle(1100, "det_b");
    check("det_b_same_map", mm_out, map_a);

    apply_reset();
    start_at(6);
    wait_idle(1100, "det_c");
    check("det_c_differs", 64'(mm_out != map_a), 64'd1);

    // Normal generation.
    repeat ($urandom_range(0, 7)) @(negedge clk);
    exclude = 64'h1;
    ld0 = ld_count;
    do_start();
    wait_idle(1100, "normal");
    check("normal_ld_count", 64'(ld_count - ld0), 64'd1);
    check("normal_latency_ok",
          64'((ld_cyc - start_cyc) >= int'(N) + 2 && (ld_cyc - start_cyc) <= int'(MAXT) + 2), 64'd1);
    check("normal_popcount", 64'($countones(mm_out)), 64'(N));
    check("normal_cell0_clear", 64'(mm_out[0]), 64'd0);
    check("normal_done_err", {62'h0, done, err}, 64'h2);

    // Dense exclusion over many starts at random gaps.
    exclude = 64'hFFFF_FFFF_0000_0000;
    for (int r = 0; r < 50; r++) begin
      repeat ($urandom_range(0, 15)) @(negedge clk);
      ld0 = ld_count;
      do_start();
      wait_idle(1100, "dense");
      check("dense_upper_clear", mm_out & 64'hFFFF_FFFF_0000_0000, 64'h0);
      check("dense_popcount", 64'($countones(mm_out)), 64'(N));
      check("dense_ld_count", 64'(ld_count - ld0), 64'd1);
    end

    // Abort: only three free cells.
    exclude = 64'hFFFF_FFFF_FFFF_FFF8;
    ld0 = ld_count;
    do_start();
    wait_idle(MAXT + 20, "abort");
    check("abort_latency", 64'(err_cyc - start_cyc), 64'(MAXT + 2));
    check("abort_no_ld", 64'(ld_count - ld0), 64'd0);
    check("abort_subset", mm_out & ~64'h7, 64'h0);
    check("abort_flags", {61'h0, busy, done, err}, 64'h1);

    // A second start while busy is ignored.
    exclude = 64'h1;
    ld0 = ld_count;
    dr0 = done_rises;
    do_start();
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(1100, "busy_start");
    repeat (5) @(negedge clk);
    check("busy_start_ld_count", 64'(ld_count - ld0), 64'd1);
    check("busy_start_done_once", 64'(done_rises - dr0), 64'd1);
    check("busy_start_idle", 64'(busy), 64'd0);

    // Reset asserted mid-PLACE, away from a clock edge.
    ld0 = ld_count;
    do_start();
    repeat (3) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("midreset_mm_out", mm_out, 64'h0);
    check("midreset_flags", {60'h0, ld_mm, busy, done, err}, 64'h0);
    repeat (2) @(negedge clk);
    check("midreset_no_ld", 64'(ld_count - ld0), 64'd0);
    resetn = 1'b1;
    ld0 = ld_count;
    repeat ($urandom_range(1, 9)) @(negedge clk);
    do_start();
    wait_idle(1100, "after_reset");
    check("after_reset_ld", 64'(ld_count - ld0), 64'd1);
    check("after_reset_popcount", 64'($countones(mm_out)), 64'(N));
    check("after_reset_done", {62'h0, done, err}, 64'h2);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
